// File: rtl/adc_avg_filter.sv
// Moving-average filter over the last 2**N_LOG2 ADC samples.
// Running-sum implementation: one circular buffer write and one add/subtract per accepted sample.
module adc_avg_filter #(
   parameter int WIDTH  = 12,
   parameter int N_LOG2 = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             in_valid,
   input  logic             clear,
   output logic [WIDTH-1:0] dout,
   output logic             out_valid,
   output logic             filled
);
   localparam int N  = 1 << N_LOG2;
   localparam int SW = WIDTH + N_LOG2;

   typedef enum logic {FILL, RUN} state_e;

   state_e              state_q;
   logic [WIDTH-1:0]    smp_q [N];
   logic [N_LOG2-1:0]   wr_ptr_q;
   logic [N_LOG2:0]     fill_cnt_q;
   logic [SW-1:0]       sum_q;
   logic [SW-1:0]       sum_d;
   logic [WIDTH-1:0]    dout_q;
   logic                out_valid_q;
   logic                filled_q;
   logic                last_fill;

   // Intermediate sum may wrap past 2**SW; the subtract brings it back in range.
   assign sum_d     = sum_q + SW'(din) - SW'(smp_q[wr_ptr_q]);
   assign last_fill = (fill_cnt_q == (N_LOG2+1)'(N - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= FILL;
         for (int i = 0; i < N; i++) smp_q[i] <= '0;
         wr_ptr_q    <= '0;
         fill_cnt_q  <= '0;
         sum_q       <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
         filled_q    <= 1'b0;
      end else if (clear) begin
         state_q     <= FILL;
         for (int i = 0; i < N; i++) smp_q[i] <= '0;
         wr_ptr_q    <= '0;
         fill_cnt_q  <= '0;
         sum_q       <= '0;
         out_valid_q <= 1'b0;
         filled_q    <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (in_valid) begin
            smp_q[wr_ptr_q] <= din;
            sum_q           <= sum_d;
            wr_ptr_q        <= wr_ptr_q + N_LOG2'(1);
            if (state_q == RUN || last_fill) begin
               out_valid_q <= 1'b1;
               dout_q      <= sum_d[SW-1:N_LOG2];
            end
            if (state_q == FILL) begin
               fill_cnt_q <= fill_cnt_q + (N_LOG2+1)'(1);
               if (last_fill) begin
                  state_q  <= RUN;
                  filled_q <= 1'b1;
               end
            end
         end
      end
   end

   assign dout      = dout_q;
   assign out_valid = out_valid_q;
   assign filled    = filled_q;
endmodule

// File: doc/adc_avg_filter.md
ADC_AVG_FILTER -- requirements
Module: adc_avg_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 12, sample width in bits (matches the ADC receiver's 12-bit sample register).
REQ-002 SHALL have parameter N_LOG2, default 3, log2 of the averaging window (window N = 2**N_LOG2 = 8 samples).
REQ-003 SHALL have port clk  input  1  system clock, single clock domain, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port din  input  WIDTH  unsigned sample from the upstream ADC sample register.
REQ-006 SHALL have port in_valid  input  1  din qualifier, one sample accepted per clk cycle while high.
REQ-007 SHALL have port clear  input  1  synchronous window flush.
REQ-008 SHALL have port dout  output  WIDTH  registered moving average.
REQ-009 SHALL have port out_valid  output  1  one-cycle strobe, dout updated this cycle.
REQ-010 SHALL have port filled  output  1  high once N samples are accepted since the last reset or clear.

Function
REQ-011 SHALL hold an N-entry circular sample buffer, a write pointer of N_LOG2 bits, a fill counter of N_LOG2+1 bits and a running sum of WIDTH+N_LOG2 bits (15 bits by default, no overflow possible).
REQ-012 SHALL implement a two-state FSM: FILL (fill counter < N) and RUN (window full).
REQ-013 SHALL, on each accepted sample, write din to buffer[wr_ptr], update sum = sum + din - buffer[wr_ptr] (old entry), and increment wr_ptr modulo N (wraps N-1 -> 0).
REQ-014 SHALL, in FILL, increment the fill counter per accepted sample and go to RUN on the Nth sample.
REQ-015 SHALL compute dout = floor(sum_next / N), i.e. sum_next right-shifted by N_LOG2, registered.
REQ-016 SHALL have latency 1: out_valid high in the cycle after the sample is accepted, for the Nth sample of the FILL phase and every sample in RUN.
REQ-017 SHALL keep out_valid low for the first N-1 samples after reset or clear, leaving dout unchanged.
REQ-018 SHALL hold dout and deassert out_valid in any cycle following one without in_valid.
REQ-019 SHALL assert filled the cycle after the transition to RUN, remaining high until reset or clear.
REQ-020 SHALL, when clear is high, zero the buffer, sum, wr_ptr and fill counter, set the state to FILL, and drive out_valid and filled low the next cycle; dout SHALL keep its last value.
REQ-021 SHALL discard a sample when in_valid and clear are high in the same cycle (clear has priority).
REQ-022 SHALL accept back-to-back samples at one per cycle with no stall and no backpressure.

Reset
REQ-023 SHALL, on a clk edge with rst low, set dout=0, out_valid=0, filled=0, sum=0, wr_ptr=0, fill counter=0, all buffer entries 0, state FILL.
REQ-024 SHALL give rst priority over clear and in_valid; a sample presented during reset is discarded.
REQ-025 SHALL apply reset equally during operation, and the first output after reset release SHALL need N fresh samples.

Verification
REQ-026 SHALL check fill: reset, then 8 consecutive in_valid with din=0x800 -> out_valid low for samples 1-7, one pulse after the 8th with dout=0x800, filled=1.
REQ-027 SHALL check step response: window full of 0x000, then 8 samples of 0xFFF -> dout sequence 0x1FF,0x3FF,0x5FF,0x7FF,0x9FF,0xBFF,0xDFF,0xFFF.
REQ-028 SHALL check truncation: after reset, samples 1,2,...,8 -> single out_valid with dout=0x004 (sum 36 >> 3).
REQ-029 SHALL check clear: in RUN, clear and in_valid (din=0xABC) high together -> sample discarded, filled=0 next cycle, next out_valid only after 8 new samples, averaging those only.
REQ-030 SHALL check reset mid-operation: in RUN with dout=0x800, rst low for one cycle while in_valid=1 -> dout=0, out_valid=0, filled=0; 8 samples of 0x100 then give dout=0x100.
REQ-031 SHALL check gapped input: in RUN, in_valid pulsed every 3rd cycle -> out_valid exactly one cycle after each pulse, dout stable in between, wr_ptr wraps correctly over 20 samples (compare to a reference model).
